arq_fifo_tx: RTL and testbench
==============================

// Module: arq_fifo_tx
// PURPOSE
//   Parametrised successor of the tiny-tapeout FIFO+ARQ transmitter: buffers DEPTH words of DATA_W,
//   sends the head word on request and waits for an internal ack/nack response.
//   Errors come from a deterministic channel model selected by err_mode. Nack retransmits the word
//   after a programmable backoff, up to MAX_RETRY times, then drops it. Instanced under the
//   tt_um_* top as the transmit datapath; bits of ui_in feed its request and error-mode inputs.
// PARAMETERS
//   DATA_W     4   payload width (bits)
//   DEPTH      8   FIFO entries; power of two, >=2
//   MAX_RETRY  3   retransmissions allowed after first attempt; 1..15
//   BACKOFF    2   idle cycles between a nack and the retransmission; 0..15
//   SEQ_W      3   sequence-number width; wraps modulo 2**SEQ_W
// PORTS
//   clk        in   1                 rising-edge clock
//   rst_n      in   1                 async active-low reset
//   wr_en      in   1                 push wr_data when not full
//   wr_data    in   DATA_W            word to enqueue
//   rd_en      in   1                 request transmission of head word (accepted in IDLE only)
//   err_mode   in   2                 channel model, latched when rd_en is accepted
//   tx_valid   out  1                 1-cycle pulse; tx_data/tx_seq/tx_attempt valid
//   tx_data    out  DATA_W            head word being sent
//   tx_seq     out  SEQ_W             sequence number of head word
//   tx_attempt out  4                 0 = first send, n = n-th retransmission
//   ack        out  1                 1-cycle pulse, word delivered and popped
//   nack       out  1                 1-cycle pulse, attempt failed
//   drop       out  1                 1-cycle pulse, retries exhausted and word popped
//   full       out  1                 count == DEPTH
//   empty      out  1                 count == 0
//   count      out  $clog2(DEPTH+1)   occupancy
//   overflow   out  1                 1-cycle pulse, write attempted while full
//   busy       out  1                 FSM not in IDLE
// BEHAVIOUR
//   Reset: all pointers, count, tx_seq, tx_attempt, tx_data, and every pulse go to 0;
//     state = IDLE; empty = 1; full = 0; busy = 0.
//   FSM states: IDLE, SEND, RESP, BACKOFF.
//     IDLE    : rd_en & !empty -> SEND, latch err_mode, attempt = 0; rd_en & empty -> ignored.
//     SEND    : tx_valid = 1 for one cycle -> RESP.
//     RESP    : exactly one of ack/nack/drop pulses, response decided by the mode table below.
//               ack  -> pop, seq++, go to IDLE.
//               nack with attempt < MAX_RETRY -> attempt++, go to BACKOFF (BACKOFF = 0: go to SEND).
//               failed with attempt == MAX_RETRY -> drop (nack not asserted), pop, seq++, go to IDLE.
//     BACKOFF : count BACKOFF cycles -> SEND.
//   Mode table (attempt a):
//     00 -> always ack
//     01 -> always fail
//     10 -> fail if a == 0, else ack
//     11 -> fail while a < MAX_RETRY, ack at a == MAX_RETRY
//   Latency: rd_en accepted at edge T -> tx_valid in cycle T+1 -> response pulse in cycle T+2.
//     Pop takes effect at the edge ending the response cycle.
//   Head word is never modified while busy; retransmissions carry identical tx_data/tx_seq.
//   Writes are accepted in any state. Push and pop on the same edge: count unchanged, both
//     pointers advance. A push when full is discarded and pulses overflow, unless a pop occurs
//     on the same edge; then the push is accepted.
//   rd_en while busy is ignored (not queued). err_mode changes mid-transaction have no effect.
//   Pointers are log2(DEPTH) bits and wrap naturally; tx_seq wraps from 2**SEQ_W-1 to 0.
//   Reset mid-transaction aborts it immediately: the FIFO is emptied and no pulse is emitted.
// STRUCTURE
//   Shared package arq_pkg: err_mode encodings (ERR_NONE, ERR_ALWAYS, ERR_ONCE, ERR_LAST) and the
//     FSM state encoding (IDLE, SEND, RESP, BACKOFF).
//   Sub-module sync_fifo_core (DATA_W, DEPTH): storage, pointers, count, full/empty, overflow,
//     head-word read port.
//   arq_fifo_tx holds the FSM, the attempt and backoff counters, the sequence counter, and the
//     mode decode.
// TESTING
//   1 Defaults: push 0,A,3,2; then rd_en with mode 00 -> tx_valid tx_data=0 seq=0;
//     ack in the next cycle; count 4->3.
//   2 Mode 10 on head A -> tx attempt0, nack, 2 idle cycles, tx attempt1 data=A seq=1,
//     ack; count 3->2.
//   3 Mode 01 on head 3 -> 4 tx_valid pulses (attempts 0..3), 3 nacks, then drop;
//     seq advances to 3.
//   4 Mode 11 with MAX_RETRY=3 -> nacks at attempts 0..2, ack at attempt 3; no drop.
//   5 Fill 8 entries, write 9th -> overflow pulse, count=8, full=1; push during an ack
//     cycle -> accepted, count stays 8.
//   6 Assert rst_n=0 during BACKOFF -> busy=0, empty=1, no ack/nack/drop; rd_en on empty
//     FIFO -> no tx_valid.

Source files
------------

// File: rtl/arq_pkg.sv
// rtl/arq_pkg.sv - shared encodings and channel-model decode for the ARQ transmit path
package arq_pkg;

  localparam int ATT_W = 4;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_ALWAYS = 2'b01,
    ERR_ONCE   = 2'b10,
    ERR_LAST   = 2'b11
  } err_mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RESP,
    S_BACKOFF
  } arq_state_e;

  // Deterministic channel: does this attempt fail under the latched mode?
  function automatic logic attempt_fails(input err_mode_e mode,
                                         input logic [ATT_W-1:0] attempt,
                                         input logic [ATT_W-1:0] max_retry);
    logic f;
    case (mode)
      ERR_NONE:   f = 1'b0;
      ERR_ALWAYS: f = 1'b1;
      ERR_ONCE:   f = (attempt == '0);
      default:    f = (attempt < max_retry);
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// rtl/sync_fifo_core.sv - circular buffer with occupancy, overflow pulse and head-word read port
module sync_fifo_core #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;
  logic              push;

  assign do_pop = pop & (count != '0);
  // A pop on the same edge frees the slot, so a write while full still lands.
  assign push   = wr_en & (~full | do_pop);
  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      overflow <= wr_en & full & ~do_pop;
    end
  end

endmodule

// File: rtl/arq_fifo_tx.sv
// rtl/arq_fifo_tx.sv - buffered stop-and-wait transmitter with retry, backoff and drop
module arq_fifo_tx
  import arq_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 2,
  parameter int SEQ_W     = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [1:0]                 err_mode,
  output logic                       tx_valid,
  output logic [DATA_W-1:0]          tx_data,
  output logic [SEQ_W-1:0]           tx_seq,
  output logic [ATT_W-1:0]           tx_attempt,
  output logic                       ack,
  output logic                       nack,
  output logic                       drop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       busy
);

  localparam logic [ATT_W-1:0] MAX_ATT = ATT_W'(MAX_RETRY);
  localparam logic [3:0]       BO_LOAD = 4'((BACKOFF == 0) ? 0 : BACKOFF - 1);

  arq_state_e        state;
  err_mode_e         mode_q;
  logic [3:0]        bo_cnt;
  logic [DATA_W-1:0] head;
  logic              pop;
  logic              fail;
  logic              can_retry;

  // The word leaves the FIFO only at the edge that closes an ack or drop cycle.
  assign pop       = (state == S_RESP) & (ack | drop);
  assign fail      = attempt_fails(mode_q, tx_attempt, MAX_ATT);
  assign can_retry = (tx_attempt < MAX_ATT);
  assign busy      = (state != S_IDLE);

  sync_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mode_q     <= ERR_NONE;
      bo_cnt     <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      tx_seq     <= '0;
      tx_attempt <= '0;
      ack        <= 1'b0;
      nack       <= 1'b0;
      drop       <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      ack      <= 1'b0;
      nack     <= 1'b0;
      drop     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_en && !empty) begin
            mode_q     <= err_mode_e'(err_mode);
            tx_attempt <= '0;
            tx_data    <= head;
            tx_valid   <= 1'b1;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          ack   <= ~fail;
          nack  <= fail & can_retry;
          drop  <= fail & ~can_retry;
          state <= S_RESP;
        end
        S_RESP: begin
          if (nack) begin
            tx_attempt <= tx_attempt + 1'b1;
            if (BACKOFF == 0) begin
              tx_data  <= head;
              tx_valid <= 1'b1;
              state    <= S_SEND;
            end else begin
              bo_cnt <= BO_LOAD;
              state  <= S_BACKOFF;
            end
          end else begin
            tx_seq <= tx_seq + 1'b1;
            state  <= S_IDLE;
          end
        end
        S_BACKOFF: begin
          if (bo_cnt == '0) begin
            tx_data  <= head;
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end else begin
            bo_cnt <= bo_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arq_fifo_tx.sv
// tb/tb_arq_fifo_tx.sv - scoreboard bench for arq_fifo_tx against a queue-based reference model
`timescale 1ns/1ps
module tb_arq_fifo_tx;

  localparam int DATA_W    = 4;
  localparam int DEPTH     = 8;
  localparam int MAX_RETRY = 3;
  localparam int BACKOFF   = 2;
  localparam int SEQ_W     = 3;
  localparam int CNT_W     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic [1:0]        err_mode = '0;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic [SEQ_W-1:0]  tx_seq;
  logic [3:0]        tx_attempt;
  logic              ack, nack, drop, full, empty, overflow, busy;
  logic [CNT_W-1:0]  count;

  arq_fifo_tx #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .BACKOFF(BACKOFF), .SEQ_W(SEQ_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .err_mode(err_mode), .tx_valid(tx_valid), .tx_data(tx_data), .tx_seq(tx_seq),
    .tx_attempt(tx_attempt), .ack(ack), .nack(nack), .drop(drop), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 tx, 1 ack, 2 nack, 3 drop; cyc is the cycle the pulse is visible
  typedef struct {
    int kind;
    int cyc;
    int data;
    int seq;
    int att;
  } evt_t;

  evt_t exp_q[$];
  int   ovf_q[$];
  int   model_q[$];
  int   model_seq = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit fails(input int mode, input int a);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (a == 0);
      default: return (a < MAX_RETRY);
    endcase
  endfunction

  // Reference: attempt a is sent (2+BACKOFF)*a cycles after the first send.
  task automatic plan(input int acc, input int mode);
    int w;
    int t;
    w = model_q.pop_front();
    for (int a = 0; a <= MAX_RETRY; a++) begin
      t = acc + a * (2 + BACKOFF);
      exp_q.push_back('{0, t, w, model_seq, a});
      if (!fails(mode, a)) begin
        exp_q.push_back('{1, t + 1, 0, 0, 0});
        break;
      end else if (a < MAX_RETRY) begin
        exp_q.push_back('{2, t + 1, 0, 0, 0});
      end else begin
        exp_q.push_back('{3, t + 1, 0, 0, 0});
      end
    end
    model_seq = (model_seq + 1) % (1 << SEQ_W);
  endtask

  task automatic see(input int kind);
    evt_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_pulse: got kind=%0d at cyc %0d, expected no pulse", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          (kind == 0 && (e.data != int'(tx_data) || e.seq != int'(tx_seq) ||
                         e.att != int'(tx_attempt)))) begin
        n_bad++;
        $display("FAIL event: got kind=%0d cyc=%0d data=%0h seq=%0d att=%0d, expected kind=%0d cyc=%0d data=%0h seq=%0d att=%0d",
                 kind, cyc, tx_data, tx_seq, tx_attempt, e.kind, e.cyc, e.data, e.seq, e.att);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid) see(0);
      if (ack)      see(1);
      if (nack)     see(2);
      if (drop)     see(3);
      if (overflow) begin
        n_cmp++;
        if (ovf_q.size() == 0 || ovf_q[0] != cyc) begin
          n_bad++;
          $display("FAIL overflow: got pulse at cyc %0d, expected %0d", cyc,
                   (ovf_q.size() == 0) ? -1 : ovf_q[0]);
        end
        if (ovf_q.size() != 0) void'(ovf_q.pop_front());
      end
    end
  end

  task automatic push(input int w);
    wr_en   = 1'b1;
    wr_data = DATA_W'(w);
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(w);
    else ovf_q.push_back(cyc);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected busy=0", n);
    end
  endtask

  task automatic check_occ(input string tag);
    chk({tag, "_count"}, int'(count), model_q.size());
    chk({tag, "_empty"}, int'(empty), int'(model_q.size() == 0));
    chk({tag, "_full"},  int'(full),  int'(model_q.size() == DEPTH));
    chk({tag, "_seq"},   int'(tx_seq), model_seq);
  endtask

  task automatic do_tx(input int mode, input string tag);
    rd_en    = 1'b1;
    err_mode = 2'(mode);
    @(posedge clk); #1;
    rd_en    = 1'b0;
    err_mode = 2'($urandom_range(0, 3));
    if (model_q.size() > 0) plan(cyc, mode);
    wait_idle();
    check_occ(tag);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_seq", int'(tx_seq), 0);
    chk("rst_att", int'(tx_attempt), 0);
    chk("rst_data", int'(tx_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    push(0); push(10); push(3); push(2);
    check_occ("t1_pre");
    do_tx(0, "t1");
    do_tx(2, "t2");
    do_tx(1, "t3");
    do_tx(3, "t4");

    for (int i = 0; i < DEPTH + 1; i++) push(i + 4);
    check_occ("t5_fill");
    rd_en = 1'b1; err_mode = 2'd0;
    @(posedge clk); #1;
    rd_en = 1'b0;
    plan(cyc, 0);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_data = 4'd9;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_q.push_back(9);
    wait_idle();
    check_occ("t5_ackpush");

    rd_en = 1'b1; err_mode = 2'd1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    plan(cyc, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_pre_events", exp_q.size(), 2 * (MAX_RETRY + 1) - 2);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_q.delete();
    model_seq = 0;
    chk("t6_busy", int'(busy), 0);
    check_occ("t6_rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    do_tx(0, "t6_empty_rd");
    chk("t6_busy_after", int'(busy), 0);

    for (int i = 0; i < 60; i++) begin
      w = $urandom_range(0, 3);
      for (int k = 0; k < w; k++) push($urandom_range(0, 15));
      do_tx($urandom_range(0, 3), "rnd");
    end

    repeat (4) @(posedge clk);
    #1;
    chk("exp_drained", exp_q.size(), 0);
    chk("ovf_drained", ovf_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
